// File: rtl/nibble_serial_adder_if.sv
// nibble_serial_adder_if
//   Operand/result handshake bundle for nibble_serial_adder.
//   Parameter NIBBLES sets the operand width W = 4*NIBBLES.
//   Signals:
//     in_valid  / in_ready   operand handshake (issuer -> adder)
//     a, b, subtract         operands and op select, sampled on accept
//     out_valid / out_ready  result handshake (adder -> writeback)
//     result                 W-bit sum or difference
//     carryout, overflow, zero  result flags
//   Modports: master = operand issuer / result consumer, slave = the adder.
interface nibble_serial_adder_if #(
  parameter int NIBBLES = 4
);
  localparam int W = 4 * NIBBLES;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         subtract;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         carryout;
  logic         overflow;
  logic         zero;

  modport master (
    output in_valid, a, b, subtract, out_ready,
    input  in_ready, out_valid, result, carryout, overflow, zero
  );

  modport slave (
    input  in_valid, a, b, subtract, out_ready,
    output in_ready, out_valid, result, carryout, overflow, zero
  );
endinterface

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder
//   Multi-cycle W-bit add/subtract built from one 4-bit ripple slice.
//   Operands are accepted in IDLE, then one nibble (LS first) is processed
//   per clock in RUN with the carry held in a register; DONE presents the
//   result and flags until the consumer takes them.
//   Ports:
//     clk    rising-edge clock
//     rst_n  synchronous active-low reset
//     bus    nibble_serial_adder_if.slave (operand and result handshakes)
//   Optional feature macro: ALU_SAT_EN
//     defined   -> on signed overflow the result saturates to the signed limit
//     undefined -> result wraps modulo 2^W, no saturation logic
module nibble_serial_adder #(
  parameter int NIBBLES = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  nibble_serial_adder_if.slave bus
);
  localparam int W  = 4 * NIBBLES;
  localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [CW-1:0] LAST_NIBBLE = CW'(NIBBLES - 1);

  logic [1:0]    r_state;
  logic [W-1:0]  r_a;
  logic [W-1:0]  r_b;
  logic [CW-1:0] r_cnt;
  logic          r_carry;
  logic [W-1:0]  r_result;
  logic          r_carryout;
  logic          r_overflow;
  logic          r_zero;

  logic [3:0]    w_nibA;
  logic [3:0]    w_nibB;
  logic [4:0]    w_sum;
  logic [W-1:0]  w_nextResult;
  logic [W-1:0]  w_finalResult;
  logic          w_overflow;
  logic          w_last;

  // r_b already holds b inverted for subtract and r_carry starts at 1, so
  // the slice is always a plain add: a + ~b + 1 = a - b.
  always_comb begin
    w_nibA       = r_a[{r_cnt, 2'b00} +: 4];
    w_nibB       = r_b[{r_cnt, 2'b00} +: 4];
    w_sum        = {1'b0, w_nibA} + {1'b0, w_nibB} + {4'b0000, r_carry};
    w_nextResult = r_result;
    w_nextResult[{r_cnt, 2'b00} +: 4] = w_sum[3:0];
    w_last       = (r_cnt == LAST_NIBBLE);
    // Only meaningful on the last nibble, when w_nextResult is complete.
    w_overflow   = (r_a[W-1] == r_b[W-1]) && (w_nextResult[W-1] != r_a[W-1]);
`ifdef ALU_SAT_EN
    if (w_overflow) begin
      w_finalResult = r_a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end else begin
      w_finalResult = w_nextResult;
    end
`else
    w_finalResult = w_nextResult;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_a        <= '0;
      r_b        <= '0;
      r_cnt      <= '0;
      r_carry    <= 1'b0;
      r_result   <= '0;
      r_carryout <= 1'b0;
      r_overflow <= 1'b0;
      r_zero     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_a     <= bus.a;
            r_b     <= bus.b ^ {W{bus.subtract}};
            r_carry <= bus.subtract;
            r_cnt   <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_carry <= w_sum[4];
          r_cnt   <= r_cnt + CW'(1);
          if (w_last) begin
            r_result   <= w_finalResult;
            r_carryout <= w_sum[4];
            r_overflow <= w_overflow;
            r_zero     <= (w_finalResult == '0);
            r_state    <= S_DONE;
          end else begin
            r_result <= w_nextResult;
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == S_IDLE);
  assign bus.out_valid = (r_state == S_DONE);
  assign bus.result    = r_result;
  assign bus.carryout  = r_carryout;
  assign bus.overflow  = r_overflow;
  assign bus.zero      = r_zero;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb_nibble_serial_adder
//   Scoreboard bench for nibble_serial_adder (NIBBLES = 4, W = 16).
//   Expected results come from an integer-arithmetic model of add/subtract,
//   pushed on accept and popped by a monitor on each output handshake.
//   Honours ALU_SAT_EN in the model when the macro is defined.
module tb_nibble_serial_adder;
  localparam int NIBBLES = 4;
  localparam int W       = 4 * NIBBLES;
  localparam longint MAX_S = (longint'(1) <<< (W - 1)) - 1;
  localparam longint MIN_S = -(longint'(1) <<< (W - 1));

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  nibble_serial_adder_if #(.NIBBLES(NIBBLES)) bus ();

  nibble_serial_adder #(.NIBBLES(NIBBLES)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct packed {
    logic [W-1:0] result;
    logic         carryout;
    logic         overflow;
    logic         zero;
  } expT;

  expT expQ[$];
  expT monExp;
  int  testsRun    = 0;
  int  testsFailed = 0;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Reference: ideal unsigned and signed integer results, then reduce.
  function automatic expT model(input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic sub);
    expT         e;
    longint      ua, ub, sa, sb, uSum, sSum;
    logic [63:0] wrapped;
    ua = longint'(a);
    ub = longint'(b);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (sub) begin
      uSum       = ua - ub;
      sSum       = sa - sb;
      e.carryout = (ua >= ub);
    end else begin
      uSum       = ua + ub;
      sSum       = sa + sb;
      e.carryout = (uSum >= (longint'(1) <<< W));
    end
    wrapped    = uSum;
    e.result   = wrapped[W-1:0];
    e.overflow = (sSum > MAX_S) || (sSum < MIN_S);
`ifdef ALU_SAT_EN
    if (sSum > MAX_S) e.result = W'(MAX_S);
    else if (sSum < MIN_S) e.result = W'(MIN_S);
`endif
    e.zero = (e.result == '0);
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (expQ.size() == 0) begin
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL unexpectedOutput: got result 0x%0h, expected no output",
                 bus.result);
      end else begin
        monExp = expQ.pop_front();
        checkOutput("result",   bus.result,   monExp.result);
        checkOutput("carryout", bus.carryout, monExp.carryout);
        checkOutput("overflow", bus.overflow, monExp.overflow);
        checkOutput("zero",     bus.zero,     monExp.zero);
      end
    end
  end

  // Called at posedge+1; leaves the bench at posedge+1 after the accept edge.
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic sub, output int acceptOk);
    int guard;
    guard = 0;
    while (!bus.in_ready && guard < 50) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (!bus.in_ready) begin
      checkOutput("acceptTimeout", bus.in_ready, 1);
      acceptOk = 0;
      return;
    end
    bus.in_valid = 1'b1;
    bus.a        = a;
    bus.b        = b;
    bus.subtract = sub;
    @(posedge clk);
    expQ.push_back(model(a, b, sub));
    #1;
    bus.in_valid = 1'b0;
    bus.a        = W'($urandom);
    bus.b        = W'($urandom);
    bus.subtract = 1'($urandom_range(0, 1));
    acceptOk     = 1;
  endtask

  // The accept edge counts as edge 1 when measuring latency.
  task automatic waitResult(input int holdCycles, input logic pokeBusy,
                            output int latency);
    latency = 1;
    if (pokeBusy) bus.in_valid = 1'b1;
    while (!bus.out_valid && latency < 100) begin
      checkOutput("busyInReady", bus.in_ready, 0);
      @(posedge clk);
      #1;
      latency++;
    end
    if (!bus.out_valid) begin
      checkOutput("resultTimeout", bus.out_valid, 1);
      bus.in_valid = 1'b0;
      return;
    end
    for (int i = 0; i < holdCycles; i++) begin
      @(posedge clk);
      #1;
      checkOutput("holdValid",   bus.out_valid, 1);
      checkOutput("holdInReady", bus.in_ready,  0);
      if (expQ.size() > 0) checkOutput("holdResult", bus.result, expQ[0].result);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    checkOutput("postHsValid",   bus.out_valid, 0);
    checkOutput("postHsInReady", bus.in_ready,  1);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "InReady"},  bus.in_ready,  1);
    checkOutput({tag, "OutValid"}, bus.out_valid, 0);
    checkOutput({tag, "Result"},   bus.result,    0);
    checkOutput({tag, "Flags"},    {bus.carryout, bus.overflow, bus.zero}, 0);
  endtask

  task automatic runOp(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic sub, input int holdCycles,
                       input logic pokeBusy, input logic checkLatency);
    int ok;
    int lat;
    applyStimulus(a, b, sub, ok);
    if (ok == 0) return;
    waitResult(holdCycles, pokeBusy, lat);
    if (checkLatency) checkOutput("latency", lat, NIBBLES + 1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          ok;
    logic [W-1:0] ra, rb;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.subtract  = 1'b0;
    bus.out_ready = 1'b0;
    rst_n         = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkResetState("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed cases
    runOp(16'h0FFF, 16'h0001, 1'b0, 0, 1'b0, 1'b1);
    runOp(16'h1234, 16'h1234, 1'b1, 0, 1'b0, 1'b1);
    runOp(16'h7FFF, 16'h0001, 1'b0, 1, 1'b0, 1'b0);
    runOp(16'h8000, 16'h0001, 1'b1, 1, 1'b0, 1'b0);
    runOp(16'hFFFF, 16'h0001, 1'b0, 0, 1'b0, 1'b0);
    runOp(16'h0000, 16'h0001, 1'b1, 0, 1'b0, 1'b0);
    runOp(16'h0000, 16'h8000, 1'b1, 0, 1'b0, 1'b0);
    runOp(16'h8000, 16'h8000, 1'b0, 0, 1'b0, 1'b0);
    // Backpressure with busy pokes
    runOp(16'h5A5A, 16'h1111, 1'b0, 10, 1'b1, 1'b1);

    // Reset in the middle of RUN abandons the operation
    applyStimulus(16'h1111, 16'h2222, 1'b0, ok);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    if (ok != 0) void'(expQ.pop_back());
    rst_n = 1'b1;
    checkResetState("midRunReset");
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      checkOutput("abandonedOutValid", bus.out_valid, 0);
    end

    // Random operations, sometimes pinned to boundary values
    for (int n = 0; n < 40; n++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      case ($urandom_range(0, 5))
        0: ra = 16'h7FFF;
        1: ra = 16'h8000;
        2: rb = ra;
        3: rb = 16'hFFFF;
        default: ;
      endcase
      runOp(ra, rb, 1'($urandom_range(0, 1)), $urandom_range(0, 3),
            1'($urandom_range(0, 1)), 1'b1);
    end

    repeat (3) @(posedge clk);
    checkOutput("queueDrained", expQ.size(), 0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end
endmodule
